// File: rtl/wb_bus_arbiter.sv
// rtl/wb_bus_arbiter.sv - round-robin arbiter sharing one pipelined Wishbone B4 port between masters D and I
module wb_bus_arbiter #(
    parameter int ADDR_W   = 30,
    parameter int DATA_W   = 32,
    parameter int MAX_OUTS = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                d_cyc,
    input  logic                d_stb,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_sel,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_ack,
    output logic                d_stall,
    output logic                d_err,
    output logic [DATA_W-1:0]   d_rdata,
    input  logic                i_cyc,
    input  logic                i_stb,
    input  logic                i_we,
    input  logic [DATA_W/8-1:0] i_sel,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [DATA_W-1:0]   i_wdata,
    output logic                i_ack,
    output logic                i_stall,
    output logic                i_err,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                o_wb_cyc,
    output logic                o_wb_stb,
    output logic                o_wb_we,
    output logic [DATA_W/8-1:0] o_wb_sel,
    output logic [ADDR_W-1:0]   o_wb_addr,
    output logic [DATA_W-1:0]   o_wb_data,
    input  logic                i_wb_ack,
    input  logic                i_wb_stall,
    input  logic [DATA_W-1:0]   i_wb_data,
    output logic [1:0]          grant
);

    localparam int OUTS_W = $clog2(MAX_OUTS + 1);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);
    localparam logic [OUTS_W-1:0] OUTS_MAX = OUTS_W'(MAX_OUTS);
    localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OWN_D,
        S_OWN_I,
        S_ERR
    } state_t;

    state_t              state, state_nx;
    logic                last_i, last_i_nx;     // 1: I was the most recent owner
    logic [OUTS_W-1:0]   outs, outs_nx;
    logic [TMO_W-1:0]    tmo, tmo_nx;

    logic                own_d, own_i, owned, in_err;
    logic                x_cyc, x_stb, x_we;
    logic [DATA_W/8-1:0] x_sel;
    logic [ADDR_W-1:0]   x_addr;
    logic [DATA_W-1:0]   x_wdata;
    logic                outs_full, stb_out, accept, ack_fwd;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            last_i <= 1'b1;
            outs   <= '0;
            tmo    <= '0;
        end else begin
            state  <= state_nx;
            last_i <= last_i_nx;
            outs   <= outs_nx;
            tmo    <= tmo_nx;
        end
    end

    assign own_d  = (state == S_OWN_D);
    assign own_i  = (state == S_OWN_I);
    assign owned  = own_d | own_i;
    assign in_err = (state == S_ERR);

    assign x_cyc   = own_d ? d_cyc   : i_cyc;
    assign x_stb   = own_d ? d_stb   : i_stb;
    assign x_we    = own_d ? d_we    : i_we;
    assign x_sel   = own_d ? d_sel   : i_sel;
    assign x_addr  = own_d ? d_addr  : i_addr;
    assign x_wdata = own_d ? d_wdata : i_wdata;

    assign outs_full = (outs == OUTS_MAX);
    assign stb_out   = owned & x_cyc & x_stb & ~outs_full;
    assign accept    = stb_out & ~i_wb_stall;
    // An ack with nothing outstanding belongs to no request of this tenure.
    assign ack_fwd   = owned & i_wb_ack & (outs != '0);

    assign o_wb_cyc  = owned & x_cyc;
    assign o_wb_stb  = stb_out;
    assign o_wb_we   = owned & x_we;
    assign o_wb_sel  = owned ? x_sel   : '0;
    assign o_wb_addr = owned ? x_addr  : '0;
    assign o_wb_data = owned ? x_wdata : '0;

    assign d_ack   = own_d & ack_fwd;
    assign i_ack   = own_i & ack_fwd;
    assign d_stall = own_d ? (i_wb_stall | outs_full) : 1'b1;
    assign i_stall = own_i ? (i_wb_stall | outs_full) : 1'b1;
    assign d_err   = in_err & ~last_i;
    assign i_err   = in_err & last_i;
    assign d_rdata = own_d ? i_wb_data : '0;
    assign i_rdata = own_i ? i_wb_data : '0;
    assign grant   = {own_i | (in_err & last_i), own_d | (in_err & ~last_i)};

    always_comb begin
        state_nx  = state;
        last_i_nx = last_i;
        outs_nx   = outs;
        tmo_nx    = tmo;
        case (state)
            S_IDLE: begin
                outs_nx = '0;
                tmo_nx  = '0;
                if (d_cyc && i_cyc)
                    state_nx = last_i ? S_OWN_D : S_OWN_I;
                else if (d_cyc)
                    state_nx = S_OWN_D;
                else if (i_cyc)
                    state_nx = S_OWN_I;
            end
            S_OWN_D, S_OWN_I: begin
                if (!x_cyc) begin
                    state_nx  = S_IDLE;
                    last_i_nx = own_i;
                    outs_nx   = '0;
                    tmo_nx    = '0;
                end else if (tmo == TMO_MAX) begin
                    state_nx  = S_ERR;
                    last_i_nx = own_i;
                    outs_nx   = '0;
                    tmo_nx    = '0;
                end else begin
                    if (accept && !ack_fwd)
                        outs_nx = outs + OUTS_W'(1);
                    else if (!accept && ack_fwd)
                        outs_nx = outs - OUTS_W'(1);
                    tmo_nx = ((outs != '0) && !i_wb_ack) ? tmo + TMO_W'(1) : '0;
                end
            end
            S_ERR: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb/tb_wb_bus_arbiter.sv - self-checking bench for wb_bus_arbiter
module tb_wb_bus_arbiter;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int MO = 4;
    localparam int TO = 255;

    logic clk = 1'b0;
    logic reset;
    logic d_cyc, d_stb, d_we, i_cyc, i_stb, i_we;
    logic [SW-1:0] d_sel, i_sel, o_wb_sel;
    logic [AW-1:0] d_addr, i_addr, o_wb_addr;
    logic [DW-1:0] d_wdata, i_wdata, d_rdata, i_rdata, o_wb_data, i_wb_data;
    logic d_ack, d_stall, d_err, i_ack, i_stall, i_err;
    logic o_wb_cyc, o_wb_stb, o_wb_we, i_wb_ack, i_wb_stall;
    logic [1:0] grant;

    always #5 clk = ~clk;

    wb_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTS(MO), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_stall(d_stall), .d_err(d_err), .d_rdata(d_rdata),
        .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_sel(i_sel), .i_addr(i_addr),
        .i_wdata(i_wdata), .i_ack(i_ack), .i_stall(i_stall), .i_err(i_err), .i_rdata(i_rdata),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_sel(o_wb_sel),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
        .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data),
        .grant(grant)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        d_cyc = 0; d_stb = 0; d_we = 0; d_sel = '0; d_addr = '0; d_wdata = '0;
        i_cyc = 0; i_stb = 0; i_we = 0; i_sel = '0; i_addr = '0; i_wdata = '0;
        i_wb_ack = 0; i_wb_stall = 0; i_wb_data = '0;
    endtask

    task automatic do_reset();
        reset = 1;
        idle_inputs();
        tick();
        tick();
        reset = 0;
    endtask

    // Reference model: owner 0=none 1=D 2=I 3=error, last 1=D 2=I
    int m_own, m_last, m_outs, m_tmo;

    task automatic model_reset();
        m_own = 0; m_last = 2; m_outs = 0; m_tmo = 0;
    endtask

    task automatic model_check();
        bit owned, xc, xs, xw, ackv;
        logic [SW-1:0] xsel;
        logic [AW-1:0] xa;
        logic [DW-1:0] xd;
        owned = (m_own == 1) || (m_own == 2);
        xc = (m_own == 1) ? d_cyc : i_cyc;
        xs = (m_own == 1) ? d_stb : i_stb;
        xw = (m_own == 1) ? d_we : i_we;
        xsel = (m_own == 1) ? d_sel : i_sel;
        xa = (m_own == 1) ? d_addr : i_addr;
        xd = (m_own == 1) ? d_wdata : i_wdata;
        ackv = i_wb_ack && (m_outs > 0);
        check("grant", grant, (m_own == 3) ? m_last : m_own);
        check("wb_cyc", o_wb_cyc, owned && xc);
        check("wb_stb", o_wb_stb, owned && xc && xs && (m_outs < MO));
        check("wb_we", o_wb_we, owned && xw);
        check("wb_sel", o_wb_sel, owned ? xsel : '0);
        check("wb_addr", o_wb_addr, owned ? xa : '0);
        check("wb_data", o_wb_data, owned ? xd : '0);
        check("d_ack", d_ack, (m_own == 1) && ackv);
        check("i_ack", i_ack, (m_own == 2) && ackv);
        check("d_stall", d_stall, (m_own == 1) ? (i_wb_stall || m_outs == MO) : 1'b1);
        check("i_stall", i_stall, (m_own == 2) ? (i_wb_stall || m_outs == MO) : 1'b1);
        check("d_err", d_err, (m_own == 3) && (m_last == 1));
        check("i_err", i_err, (m_own == 3) && (m_last == 2));
        check("d_rdata", d_rdata, (m_own == 1) ? i_wb_data : '0);
        check("i_rdata", i_rdata, (m_own == 2) ? i_wb_data : '0);
    endtask

    task automatic model_step();
        bit xc, xs, acc, ackv;
        if (reset) begin
            model_reset();
            return;
        end
        case (m_own)
            0: begin
                if (d_cyc && i_cyc) m_own = (m_last == 1) ? 2 : 1;
                else if (d_cyc) m_own = 1;
                else if (i_cyc) m_own = 2;
            end
            1, 2: begin
                xc = (m_own == 1) ? d_cyc : i_cyc;
                xs = (m_own == 1) ? d_stb : i_stb;
                if (!xc) begin
                    m_last = m_own; m_own = 0; m_outs = 0; m_tmo = 0;
                end else if (m_tmo == TO) begin
                    m_last = m_own; m_own = 3; m_outs = 0; m_tmo = 0;
                end else begin
                    acc  = xs && (m_outs < MO) && !i_wb_stall;
                    ackv = i_wb_ack && (m_outs > 0);
                    m_tmo = (m_outs > 0 && !i_wb_ack) ? m_tmo + 1 : 0;
                    m_outs = m_outs + int'(acc) - int'(ackv);
                end
            end
            default: m_own = 0;
        endcase
    endtask

    typedef struct {
        logic       dc;
        logic       ic;
        logic [1:0] exp_grant;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int accepted;
        vecs[0] = '{dc: 1'b0, ic: 1'b0, exp_grant: 2'b00};
        vecs[1] = '{dc: 1'b1, ic: 1'b0, exp_grant: 2'b01};
        vecs[2] = '{dc: 1'b0, ic: 1'b1, exp_grant: 2'b10};
        vecs[3] = '{dc: 1'b1, ic: 1'b1, exp_grant: 2'b01};

        // reset state
        do_reset();
        check("rst_grant", grant, 2'b00);
        check("rst_cyc", o_wb_cyc, 1'b0);
        check("rst_stb", o_wb_stb, 1'b0);
        check("rst_d_stall", d_stall, 1'b1);
        check("rst_i_stall", i_stall, 1'b1);
        check("rst_acks", {d_ack, i_ack, d_err, i_err}, 4'b0);

        // arbitration from reset, registered grant
        for (int k = 0; k < 4; k++) begin
            do_reset();
            d_cyc = vecs[k].dc;
            i_cyc = vecs[k].ic;
            #1;
            check("vec_pre_grant", grant, 2'b00);
            tick();
            check("vec_grant", grant, vecs[k].exp_grant);
            check("vec_cyc", o_wb_cyc, vecs[k].exp_grant != 2'b00);
        end

        // single D read with 1-cycle slave ack
        do_reset();
        d_cyc = 1; d_stb = 1; d_sel = 4'hf; d_addr = 30'h10;
        #1;
        check("d1_stb_n", o_wb_stb, 1'b0);
        tick();
        check("d1_stb_n1", o_wb_stb, 1'b1);
        check("d1_addr", o_wb_addr, 30'h10);
        check("d1_grant", grant, 2'b01);
        check("d1_noack", d_ack, 1'b0);
        tick();
        d_stb = 0; i_wb_ack = 1; i_wb_data = 32'hdeadbeef;
        #1;
        check("d1_ack", d_ack, 1'b1);
        check("d1_rdata", d_rdata, 32'hdeadbeef);
        check("d1_i_ack", i_ack, 1'b0);
        check("d1_i_rdata", i_rdata, 32'h0);
        i_wb_ack = 0; d_cyc = 0;
        tick();
        tick();

        // contention, release, one idle cycle, then I
        do_reset();
        d_cyc = 1; i_cyc = 1;
        tick();
        check("rr_first_d", grant, 2'b01);
        d_cyc = 0;
        tick();
        check("rr_idle_gap", grant, 2'b00);
        tick();
        check("rr_then_i", grant, 2'b10);
        i_cyc = 0;
        tick();
        tick();

        // I issues strobes, slave never acks: outstanding limit
        do_reset();
        i_cyc = 1; i_stb = 1;
        tick();
        accepted = 0;
        for (int k = 0; k < 6; k++) begin
            if (o_wb_stb && !i_wb_stall) accepted++;
            tick();
        end
        check("outs_accepted", accepted, MO);
        check("outs_i_stall", i_stall, 1'b1);
        check("outs_stb_blocked", o_wb_stb, 1'b0);
        i_cyc = 0; i_stb = 0;
        tick();
        tick();

        // slave stall holds the request
        do_reset();
        i_wb_stall = 1; d_cyc = 1; d_stb = 1; d_addr = 30'h20;
        tick();
        for (int k = 0; k < 3; k++) begin
            check("stall_d_stall", d_stall, 1'b1);
            check("stall_addr", o_wb_addr, 30'h20);
            check("stall_stb", o_wb_stb, 1'b1);
            tick();
        end
        i_wb_stall = 0;
        #1;
        check("stall_release", d_stall, 1'b0);
        tick();
        d_stb = 0; i_wb_ack = 1;
        #1;
        check("stall_one_ack", d_ack, 1'b1);
        tick();
        check("stall_extra_ack", d_ack, 1'b0);
        i_wb_ack = 0; d_cyc = 0;
        tick();
        tick();

        // timeout
        do_reset();
        d_cyc = 1; d_stb = 1;
        tick();
        n = 0;
        tick();
        n = 1;
        d_stb = 0;
        while (!d_err && n < 400) begin
            tick();
            n++;
        end
        check("tmo_cycles", n, TO + 2);
        check("tmo_cyc_low", o_wb_cyc, 1'b0);
        check("tmo_grant", grant, 2'b01);
        check("tmo_i_err", i_err, 1'b0);
        d_cyc = 0; i_wb_ack = 1;
        tick();
        check("tmo_err_pulse", d_err, 1'b0);
        check("tmo_late_ack", d_ack, 1'b0);
        check("tmo_idle", grant, 2'b00);
        i_wb_ack = 0;
        tick();

        // reset with two requests outstanding
        do_reset();
        d_cyc = 1; d_stb = 1;
        tick();
        tick();
        tick();
        check("rmid_busy", o_wb_cyc, 1'b1);
        reset = 1;
        tick();
        check("rmid_cyc", o_wb_cyc, 1'b0);
        check("rmid_stb", o_wb_stb, 1'b0);
        check("rmid_bus", {o_wb_we, o_wb_sel, o_wb_addr}, '0);
        check("rmid_grant", grant, 2'b00);
        check("rmid_stalls", {d_stall, i_stall}, 2'b11);
        reset = 0;
        idle_inputs();
        tick();

        // randomized traffic against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            if (d_cyc) d_cyc = ($urandom_range(0, 15) != 0);
            else       d_cyc = ($urandom_range(0, 3) == 0);
            if (i_cyc) i_cyc = ($urandom_range(0, 15) != 0);
            else       i_cyc = ($urandom_range(0, 3) == 0);
            d_stb = d_cyc & $urandom_range(0, 1);
            i_stb = i_cyc & $urandom_range(0, 1);
            d_we = $urandom_range(0, 1);
            i_we = $urandom_range(0, 1);
            d_sel = SW'($urandom);
            i_sel = SW'($urandom);
            d_addr = AW'($urandom);
            i_addr = AW'($urandom);
            d_wdata = $urandom;
            i_wdata = $urandom;
            i_wb_stall = ($urandom_range(0, 3) == 0);
            i_wb_ack = ($urandom_range(0, 2) == 0);
            i_wb_data = $urandom;
            reset = ($urandom_range(0, 499) == 0);
            #1;
            model_check();
            @(posedge clk);
            model_step();
            #1;
        end
        reset = 0;
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
